// File: rtl/out_shift_ctrl_pkg.sv
// Shared types and helpers for the output-column shift-register sequencer.
package out_shift_ctrl_pkg;

  localparam int unsigned N_DEFAULT         = 3;
  localparam int unsigned LEN_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CONFIG,
    RUN,
    DONE
  } state_e;

  // Column-count fields must be able to hold the value n itself.
  function automatic int unsigned num_col_width(input int unsigned n);
    return unsigned'($clog2(n + 1));
  endfunction

  function automatic logic cfg_legal(input int unsigned cols,
                                     input int unsigned len,
                                     input int unsigned n);
    return (cols != 0) && (cols <= n) && (len != 0);
  endfunction

endpackage

// File: rtl/out_shift_ctrl_valid_delay_line.sv
// Valid-bit shift chain that mirrors the datapath's data shift register and tap.
module valid_delay_line #(
  parameter int unsigned N             = 3,
  parameter int unsigned NUM_COL_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     in_valid_i,
  input  logic [NUM_COL_WIDTH-1:0] cols_i,
  output logic                     tap_o
);

  logic [N-2:0] vld_q;
  logic [N-2:0] vld_d;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid_i;
    for (int unsigned i = 1; i < N - 1; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q <= vld_d;
    end
  end

  // Full width bypasses the chain; otherwise stage N-cols-1 lines up with the data tap.
  always_comb begin
    tap_o = 1'b0;
    if (cols_i == NUM_COL_WIDTH'(N)) begin
      tap_o = in_valid_i;
    end else begin
      for (int unsigned i = 0; i < N - 1; i++) begin
        if (cols_i == NUM_COL_WIDTH'(N - 1 - i)) begin
          tap_o = vld_q[i];
        end
      end
    end
  end

endmodule

// File: rtl/out_shift_ctrl.sv
// Per-column sequencer: configures the output shift register, tracks valid
// samples through a matching delay line and counts a run of samples.
module out_shift_ctrl
  import out_shift_ctrl_pkg::*;
#(
  parameter int unsigned N             = N_DEFAULT,
  parameter int unsigned NUM_COL_WIDTH = num_col_width(N),
  parameter int unsigned LEN_WIDTH     = LEN_WIDTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NUM_COL_WIDTH-1:0] cfg_num_cols_i,
  input  logic [LEN_WIDTH-1:0]     cfg_len_i,
  input  logic                     in_valid_i,
  output logic [NUM_COL_WIDTH-1:0] number_of_columns_o,
  output logic                     number_of_columns_ld_o,
  output logic                     number_of_columns_rst_o,
  output logic                     out_reg_shift_rst_o,
  output logic                     out_valid_o,
  output logic                     out_last_o,
  output logic [LEN_WIDTH-1:0]     sample_cnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cfg_err_o,
  output logic                     overrun_o
);

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ld_q;
  logic                     sr_rst_q;
  logic                     cfg_err_q;
  logic                     overrun_q;
  logic [NUM_COL_WIDTH-1:0] num_cols_q;
  logic [NUM_COL_WIDTH-1:0] cols_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     sample_cnt_q;
  logic [LEN_WIDTH-1:0]     sample_cnt_d;
  logic [LEN_WIDTH-1:0]     in_cnt_q;
  logic [LEN_WIDTH-1:0]     in_cnt_d;

  logic cfg_ok;
  logic in_run;
  logic acc_valid;
  logic tap;
  logic out_valid;
  logic out_last;
  logic over_in;

  assign cfg_ok = cfg_legal(32'(cfg_num_cols_i), 32'(cfg_len_i), N);
  assign in_run = (state_q == RUN);

  // Inputs beyond len are dropped before the delay line, so they can never surface.
  assign acc_valid = in_run && in_valid_i && (in_cnt_q < len_q);
  assign over_in   = in_run && in_valid_i && (in_cnt_q == len_q);

  valid_delay_line #(
    .N             (N),
    .NUM_COL_WIDTH (NUM_COL_WIDTH)
  ) u_vld_line (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (state_q == CONFIG),
    .en_i       (in_run),
    .in_valid_i (acc_valid),
    .cols_i     (cols_q),
    .tap_o      (tap)
  );

  assign out_valid = in_run && tap && (sample_cnt_q < len_q);
  assign out_last  = out_valid && (sample_cnt_q == (len_q - LEN_WIDTH'(1)));

  assign sample_cnt_d = out_valid ? (sample_cnt_q + LEN_WIDTH'(1)) : sample_cnt_q;
  assign in_cnt_d     = acc_valid ? (in_cnt_q + LEN_WIDTH'(1)) : in_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ld_q         <= 1'b0;
      sr_rst_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      num_cols_q   <= '0;
      cols_q       <= '0;
      len_q        <= '0;
      sample_cnt_q <= '0;
      in_cnt_q     <= '0;
    end else begin
      ld_q     <= 1'b0;
      sr_rst_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cfg_ok) begin
              cols_q     <= cfg_num_cols_i;
              len_q      <= cfg_len_i;
              num_cols_q <= cfg_num_cols_i;
              cfg_err_q  <= 1'b0;
              overrun_q  <= 1'b0;
              ld_q       <= 1'b1;
              sr_rst_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= CONFIG;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        CONFIG: begin
          sample_cnt_q <= '0;
          in_cnt_q     <= '0;
          state_q      <= RUN;
        end
        RUN: begin
          sample_cnt_q <= sample_cnt_d;
          in_cnt_q     <= in_cnt_d;
          if (over_in) begin
            overrun_q <= 1'b1;
          end
          if (out_last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign number_of_columns_o     = num_cols_q;
  assign number_of_columns_ld_o  = ld_q;
  assign number_of_columns_rst_o = rst_i;
  assign out_reg_shift_rst_o     = sr_rst_q;
  assign out_valid_o             = out_valid;
  assign out_last_o              = out_last;
  assign sample_cnt_o            = sample_cnt_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign cfg_err_o               = cfg_err_q;
  assign overrun_o               = overrun_q;

endmodule

// File: tb/tb_out_shift_ctrl.sv
// Randomized self-checking bench for out_shift_ctrl against a per-run schedule model.
module tb_out_shift_ctrl;

  localparam int N    = 3;
  localparam int NCW  = $clog2(N + 1);
  localparam int LW   = 8;
  localparam int MAXT = 256;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [NCW-1:0] cfg_num_cols_i;
  logic [LW-1:0]  cfg_len_i;
  logic           in_valid_i;
  logic [NCW-1:0] number_of_columns_o;
  logic           number_of_columns_ld_o;
  logic           number_of_columns_rst_o;
  logic           out_reg_shift_rst_o;
  logic           out_valid_o;
  logic           out_last_o;
  logic [LW-1:0]  sample_cnt_o;
  logic           busy_o;
  logic           done_o;
  logic           cfg_err_o;
  logic           overrun_o;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  out_shift_ctrl #(
    .N             (N),
    .NUM_COL_WIDTH (NCW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .start_i                 (start_i),
    .cfg_num_cols_i          (cfg_num_cols_i),
    .cfg_len_i               (cfg_len_i),
    .in_valid_i              (in_valid_i),
    .number_of_columns_o     (number_of_columns_o),
    .number_of_columns_ld_o  (number_of_columns_ld_o),
    .number_of_columns_rst_o (number_of_columns_rst_o),
    .out_reg_shift_rst_o     (out_reg_shift_rst_o),
    .out_valid_o             (out_valid_o),
    .out_last_o              (out_last_o),
    .sample_cnt_o            (sample_cnt_o),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .cfg_err_o               (cfg_err_o),
    .overrun_o               (overrun_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_ncols"}, 32'(number_of_columns_o), 0);
    chk({tag, "_ld"}, 32'(number_of_columns_ld_o), 0);
    chk({tag, "_srst"}, 32'(out_reg_shift_rst_o), 0);
    chk({tag, "_ncrst"}, 32'(number_of_columns_rst_o), 1);
    chk({tag, "_vld"}, 32'(out_valid_o), 0);
    chk({tag, "_last"}, 32'(out_last_o), 0);
    chk({tag, "_cnt"}, 32'(sample_cnt_o), 0);
    chk({tag, "_err"}, 32'(cfg_err_o), 0);
    chk({tag, "_ovr"}, 32'(overrun_o), 0);
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic bad_cfg(input int cols, input int len);
    cfg_num_cols_i = NCW'(cols);
    cfg_len_i      = LW'(len);
    start_i        = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    exp_err = 1;
    chk("bad_err", 32'(cfg_err_o), 32'(exp_err));
    chk("bad_busy", 32'(busy_o), 0);
    chk("bad_ld", 32'(number_of_columns_ld_o), 0);
    chk("bad_srst", 32'(out_reg_shift_rst_o), 0);
  endtask

  // Model: the k-th input of RUN (k < len) appears N-cols cycles later;
  // the run ends on the len-th output; any further input in RUN is an overrun.
  task automatic run_one(input int cols, input int len, input int dens,
                         input logic [31:0] mask, input bit use_mask,
                         input int abort_at, input bit hold);
    bit vin [0:MAXT-1];
    bit eov [0:MAXT-1];
    int lat, k, last, cnt, nin;
    bit aborted;
    lat = N - cols;
    k = 0;
    last = -1;
    aborted = 0;
    for (int t = 0; t < MAXT; t++) begin
      eov[t] = 1'b0;
      if (use_mask) vin[t] = (t < 32) ? mask[t] : 1'b1;
      else          vin[t] = (t >= 100) ? 1'b1 : ($urandom_range(99, 0) < dens);
    end
    for (int t = 0; t < MAXT - N && last < 0; t++) begin
      if (vin[t]) begin
        eov[t + lat] = 1'b1;
        k++;
        if (k == len) last = t + lat;
      end
    end

    cfg_num_cols_i = NCW'(cols);
    cfg_len_i      = LW'(len);
    start_i        = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    in_valid_i = 1'($urandom_range(1, 0));
    @(negedge clk);
    exp_err = 0;
    chk("cfg_ld", 32'(number_of_columns_ld_o), 1);
    chk("cfg_srst", 32'(out_reg_shift_rst_o), 1);
    chk("cfg_ncols", 32'(number_of_columns_o), 32'(cols));
    chk("cfg_busy", 32'(busy_o), 1);
    chk("cfg_err", 32'(cfg_err_o), 32'(exp_err));
    chk("cfg_ovr", 32'(overrun_o), 0);
    chk("cfg_vld", 32'(out_valid_o), 0);

    cnt = 0;
    nin = 0;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      in_valid_i = vin[t];
      @(negedge clk);
      chk("run_vld", 32'(out_valid_o), 32'(eov[t]));
      chk("run_last", 32'(out_last_o), 32'(t == last));
      chk("run_cnt", 32'(sample_cnt_o), 32'(cnt));
      chk("run_ovr", 32'(overrun_o), 32'(nin > len));
      chk("run_ld", 32'(number_of_columns_ld_o), 0);
      chk("run_busy", 32'(busy_o), 1);
      chk("run_done", 32'(done_o), 0);
      if (eov[t]) cnt++;
      if (vin[t]) nin++;
      if (t == abort_at) begin
        rst_i = 1'b1;
        #1;
        chk_cleared("abort");
        #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        start_i = 1'b0;
        exp_err = 0;
        aborted = 1;
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy_o), 0);
        break;
      end
    end
    if (!aborted) begin
      @(posedge clk); #1;
      in_valid_i = 1'($urandom_range(1, 0));
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 1);
      chk("done_busy", 32'(busy_o), 1);
      chk("done_cnt", 32'(sample_cnt_o), 32'(len));
      chk("done_vld", 32'(out_valid_o), 0);
      chk("done_ovr", 32'(overrun_o), 32'(nin > len));
      chk("done_ld", 32'(number_of_columns_ld_o), 0);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("idle_done", 32'(done_o), 0);
      chk("idle_busy", 32'(busy_o), 0);
      chk("idle_ld", 32'(number_of_columns_ld_o), 0);
      chk("idle_ovr", 32'(overrun_o), 32'(nin > len));
      chk("idle_cnt", 32'(sample_cnt_o), 32'(len));
      chk("idle_ncols", 32'(number_of_columns_o), 32'(cols));
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    start_i        = 1'b0;
    in_valid_i     = 1'b0;
    cfg_num_cols_i = '0;
    cfg_len_i      = '0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_i = 1'b0;
    @(negedge clk);

    run_one(1, 4, 0, 32'hF, 1'b1, -1, 1'b0);
    run_one(3, 2, 0, 32'hA, 1'b1, -1, 1'b0);
    bad_cfg(0, 3);
    bad_cfg(4, 3);
    bad_cfg(2, 0);
    run_one(2, 2, 0, 32'h7, 1'b1, -1, 1'b0);
    run_one(1, 4, 0, 32'hF, 1'b1, 3, 1'b0);
    run_one(2, 3, 0, 32'h1F, 1'b1, -1, 1'b0);
    run_one(3, 3, 0, 32'h5, 1'b1, -1, 1'b1);
    run_one(1, 2, 0, 32'h3, 1'b1, -1, 1'b1);
    run_one(2, 1, 0, 32'h1, 1'b1, -1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(5, 0) == 0) bad_cfg(0, $urandom_range(20, 1));
      run_one($urandom_range(N, 1), $urandom_range(20, 1), $urandom_range(100, 20),
              32'h0, 1'b0, -1, 1'($urandom_range(3, 0) == 0));
    end
    start_i = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
